rc5_block_encryptor: RTL and testbench
======================================

// Module: rc5_block_encryptor
// PURPOSE
//  RC5-w/r/b encryption core downstream of the key-expansion stage. Reads S[0..T-1] from the
//  S table RAM after key expansion completes and encrypts one 2-word block (A,B) per request.
//  Uses iterative rounds: one S word is consumed per clock, and the S RAM read is pipelined.
// PARAMETERS
//  W        32  word width (bits); A, B and S entries
//  R        12  number of rounds
//  T        2*(R+1)=26  S table depth
//  T_LENGTH $clog2(T)=5  S address width
//  W_BITS   $clog2(W)=5  rotate-amount width
// PORTS
//  clk         in   1         single clock, rising edge
//  rst         in   1         synchronous, active-low reset
//  iKeyReady   in   1         key expansion finished (keyExpanderDone); S table is valid
//  iValid      in   1         plaintext offered
//  iPlainA     in   W         plaintext word A
//  iPlainB     in   W         plaintext word B
//  oReady      out  1         block can accept plaintext this cycle
//  oS_address  out  T_LENGTH  S RAM read address (registered)
//  iS_sub_i    in   W         S RAM q_a, valid the cycle after oS_address is presented
//  oValid      out  1         ciphertext valid; held until taken
//  iReady      in   1         downstream accepts ciphertext
//  oCipherA    out  W         ciphertext word A
//  oCipherB    out  W         ciphertext word B
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): state=IDLE; oValid=0; oS_address=0; A=B=0; oCipherA/B=0; idx=0.
//  Reset mid-operation aborts the block and discards it. No output is produced.
//  oReady = (state==IDLE) && iKeyReady. It is combinational.
//  Accept = iValid && oReady. iValid with iKeyReady=0 is ignored, and the plaintext is not latched.
//  iKeyReady is sampled only at accept. A drop during a block is ignored.
//  FSM:
//   IDLE  -> on accept: A<=iPlainA, B<=iPlainB, oS_address<=0, idx<=0, go to FETCH
//   FETCH -> one wait cycle for RAM latency; oS_address<=1; go to RUN
//   RUN   -> consume iS_sub_i = S[idx] each cycle; oS_address<=idx+2 (no issue past T-1)
//            idx==0: A<=A+S[0]
//            idx==1: B<=B+S[1]
//            idx even>=2: A<=ROTL(A^B, B[W_BITS-1:0]) + S[idx]
//            idx odd >=3: B<=ROTL(B^A, A[W_BITS-1:0]) + S[idx]  (uses the updated A)
//            idx==T-1: load oCipherA/B with the final A/B, oValid<=1, go to DONE; else idx<=idx+1
//   DONE  -> hold oValid and the outputs stable; on iReady: oValid<=0, go to IDLE
//  All additions are modulo 2^W, and the carry is dropped. The rotate amount is the low W_BITS bits only.
//  A rotate amount of 0 is the identity.
//  Latency: accept in cycle 0 -> oValid=1 in cycle T+2 (28).
//  Throughput: one block per T+3 cycles minimum.
//  No back-to-back overlap: oReady=0 in FETCH, RUN and DONE.
//  A new accept is possible at the earliest in the cycle after the oValid&&iReady cycle.
//  oS_address stays within 0..T-1 and never wraps. After idx==T-2 the address is held at T-1.
//  oCipherA/B change only on the DONE entry edge and on reset.
// STRUCTURE
//  Shared header rc5_defs.vh holds w, r, t, t_length, qW, pW and the FSM state encodings
//  (IDLE, FETCH, RUN, DONE). The key-expansion stage uses the same header.
//  Sub-module rc5_rotl: combinational variable rotate-left, parameter W, ports iData, iAmount, oData.
//  Two instances: one for the A-half and one for the B-half.
//  The top level instantiates the S RAM read port externally. This block owns no RAM.
// TESTING
//  1 All-zero S table, plaintext A=0,B=0 -> oCipherA=0, oCipherB=0; oValid first high 28 cycles after accept.
//  2 S from an all-zero 16-byte key via the full key expander, plaintext 0/0
//    -> oCipherA=32'hEEDBA521, oCipherB=32'h6D8F4B15.
//  3 iKeyReady=0 with iValid=1 for 10 cycles -> oReady=0, no oS_address activity, oValid stays 0.
//    Then iKeyReady=1 -> accept next cycle.
//  4 Backpressure: iReady=0 for 5 cycles after oValid -> oValid and ciphertext held stable.
//    oReady=0 until the cycle after the iReady pulse.
//  5 rst=0 at cycle 12 of a block -> next cycle IDLE with all outputs 0. No oValid for the aborted block.
//    The next block encrypts correctly.
//  6 S[all]=32'h1F, A=32'h80000000, B=0 vs. a C reference model.
//    Checks the wraps at rotate-by-31 and at mod-2^32 addition; 100 random blocks compared to the model.

Source files
------------

// File: rtl/rc5_block_encryptor_pkg.sv
// Shared RC5-32/12 constants, FSM encoding and block payload type.
// Used by the encryptor core and by the key-expansion stage.
package rc5_block_encryptor_pkg;

    localparam int unsigned W        = 32;
    localparam int unsigned R        = 12;
    localparam int unsigned T        = 2 * (R + 1);
    localparam int unsigned T_LENGTH = $clog2(T);
    localparam int unsigned W_BITS   = $clog2(W);

    // Magic constants of the key schedule (Pw, Qw for w=32).
    localparam logic [W-1:0] P_W = 32'hB7E15163;
    localparam logic [W-1:0] Q_W = 32'h9E3779B9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } block_t;

endpackage

// File: rtl/rc5_rotl.sv
// Combinational variable rotate-left.
// Ports: iData (W) value to rotate, iAmount (log2 W) rotate distance, oData (W) result.
// An amount of 0 returns iData unchanged.
module rc5_rotl #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = $clog2(W)
) (
    input  logic [W-1:0]  iData,
    input  logic [AW-1:0] iAmount,
    output logic [W-1:0]  oData
);

    // Shifting the doubled word left leaves the rotated value in the upper half.
    logic [2*W-1:0] w_dbl;

    assign w_dbl = {iData, iData} << iAmount;
    assign oData = w_dbl[2*W-1:W];

endmodule

// File: rtl/rc5_block_encryptor.sv
// RC5-32/12 iterative encryption core. Streams S[0..T-1] from an external
// synchronous-read S RAM (one word per clock) and encrypts one (A,B) block per request.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   iKeyReady           S table valid (key expansion finished)
//   iValid/oReady       plaintext handshake; oReady is combinational
//   iPlainA/iPlainB     plaintext words
//   oS_address          registered S RAM read address
//   iS_sub_i            S RAM read data, one cycle after oS_address
//   oValid/iReady       ciphertext handshake; oValid held until taken
//   oCipherA/oCipherB   ciphertext words
module rc5_block_encryptor
    import rc5_block_encryptor_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                iKeyReady,
    input  logic                iValid,
    input  logic [W-1:0]        iPlainA,
    input  logic [W-1:0]        iPlainB,
    output logic                oReady,
    output logic [T_LENGTH-1:0] oS_address,
    input  logic [W-1:0]        iS_sub_i,
    output logic                oValid,
    input  logic                iReady,
    output logic [W-1:0]        oCipherA,
    output logic [W-1:0]        oCipherB
);

    state_t              r_state, w_state_nxt;
    logic [W-1:0]        r_a, w_a_nxt;
    logic [W-1:0]        r_b, w_b_nxt;
    logic [T_LENGTH-1:0] r_idx, w_idx_nxt;
    logic [T_LENGTH-1:0] r_addr, w_addr_nxt;
    logic                r_valid, w_valid_nxt;
    logic [W-1:0]        r_ca, w_ca_nxt;
    logic [W-1:0]        r_cb, w_cb_nxt;

    logic                w_ready;
    logic [W-1:0]        w_rot_a;
    logic [W-1:0]        w_rot_b;
    logic [W-1:0]        w_a_step;
    logic [W-1:0]        w_b_step;
    logic [T_LENGTH-1:0] w_addr_run;

    assign w_ready = (r_state == IDLE) && iKeyReady;

    // Half-round datapaths; the B half sees A already updated by the previous cycle.
    rc5_rotl #(.W(W)) u_rotl_a (
        .iData   (r_a ^ r_b),
        .iAmount (r_b[W_BITS-1:0]),
        .oData   (w_rot_a)
    );

    rc5_rotl #(.W(W)) u_rotl_b (
        .iData   (r_b ^ r_a),
        .iAmount (r_a[W_BITS-1:0]),
        .oData   (w_rot_b)
    );

    assign w_a_step = w_rot_a + iS_sub_i;
    assign w_b_step = w_rot_b + iS_sub_i;

    // Prefetch two ahead of the word being consumed, saturating at the last entry.
    assign w_addr_run = (r_idx >= T_LENGTH'(T - 2)) ? T_LENGTH'(T - 1)
                                                    : r_idx + T_LENGTH'(2);

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_idx_nxt   = r_idx;
        w_addr_nxt  = r_addr;
        w_valid_nxt = r_valid;
        w_ca_nxt    = r_ca;
        w_cb_nxt    = r_cb;

        case (r_state)
            IDLE: begin
                if (iValid && w_ready) begin
                    w_a_nxt     = iPlainA;
                    w_b_nxt     = iPlainB;
                    w_addr_nxt  = T_LENGTH'(0);
                    w_idx_nxt   = T_LENGTH'(0);
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                w_addr_nxt  = T_LENGTH'(1);
                w_state_nxt = RUN;
            end
            RUN: begin
                w_addr_nxt = w_addr_run;
                if (r_idx == T_LENGTH'(0)) begin
                    w_a_nxt = r_a + iS_sub_i;
                end else if (r_idx == T_LENGTH'(1)) begin
                    w_b_nxt = r_b + iS_sub_i;
                end else if (!r_idx[0]) begin
                    w_a_nxt = w_a_step;
                end else begin
                    w_b_nxt = w_b_step;
                end
                // T-1 is odd, so the last word always finishes the B half.
                if (r_idx == T_LENGTH'(T - 1)) begin
                    w_ca_nxt    = r_a;
                    w_cb_nxt    = w_b_step;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt = r_idx + T_LENGTH'(1);
                end
            end
            DONE: begin
                if (iReady) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_ca    <= '0;
            r_cb    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_idx   <= w_idx_nxt;
            r_addr  <= w_addr_nxt;
            r_valid <= w_valid_nxt;
            r_ca    <= w_ca_nxt;
            r_cb    <= w_cb_nxt;
        end
    end

    assign oReady     = w_ready;
    assign oS_address = r_addr;
    assign oValid     = r_valid;
    assign oCipherA   = r_ca;
    assign oCipherB   = r_cb;

endmodule

// File: tb/tb_rc5_block_encryptor.sv
// Self-checking bench for rc5_block_encryptor with a behavioural S RAM,
// an RC5 reference model and a queue-based scoreboard.
module tb_rc5_block_encryptor;
    import rc5_block_encryptor_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        iKeyReady;
    logic        iValid;
    logic [31:0] iPlainA;
    logic [31:0] iPlainB;
    logic        oReady;
    logic [4:0]  oS_address;
    logic [31:0] iS_sub_i;
    logic        oValid;
    logic        iReady;
    logic [31:0] oCipherA;
    logic [31:0] oCipherB;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] s_mem [0:25];
    block_t      exp_q [$];

    always #5 clk = ~clk;

    // Synchronous-read S RAM.
    always @(posedge clk) iS_sub_i <= s_mem[oS_address];

    rc5_block_encryptor dut (
        .clk        (clk),
        .rst        (rst),
        .iKeyReady  (iKeyReady),
        .iValid     (iValid),
        .iPlainA    (iPlainA),
        .iPlainB    (iPlainB),
        .oReady     (oReady),
        .oS_address (oS_address),
        .iS_sub_i   (iS_sub_i),
        .oValid     (oValid),
        .iReady     (iReady),
        .oCipherA   (oCipherA),
        .oCipherB   (oCipherB)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_rotl(input logic [31:0] x, input logic [4:0] n);
        int unsigned sh;
        if (n == 5'd0) return x;
        sh = 32 - int'(n);
        return (x << n) | (x >> sh);
    endfunction

    function automatic block_t ref_encrypt(input logic [31:0] pa, input logic [31:0] pb);
        logic [31:0] a, b;
        block_t      res;
        a = pa + s_mem[0];
        b = pb + s_mem[1];
        for (int i = 1; i <= 12; i++) begin
            a = ref_rotl(a ^ b, b[4:0]) + s_mem[2*i];
            b = ref_rotl(b ^ a, a[4:0]) + s_mem[2*i+1];
        end
        res.a = a;
        res.b = b;
        return res;
    endfunction

    function automatic void fill_s_const(input logic [31:0] v);
        for (int i = 0; i < 26; i++) s_mem[i] = v;
    endfunction

    function automatic void fill_s_random();
        for (int i = 0; i < 26; i++) s_mem[i] = $urandom;
    endfunction

    // Standard RC5 key schedule for a 16-byte all-zero key.
    function automatic void fill_s_zero_key();
        logic [31:0] l [0:3];
        logic [31:0] a, b, ab;
        int          i, j;
        for (int k = 0; k < 4; k++) l[k] = 32'h0;
        s_mem[0] = 32'hB7E15163;
        for (int k = 1; k < 26; k++) s_mem[k] = s_mem[k-1] + 32'h9E3779B9;
        a = 0; b = 0; i = 0; j = 0;
        for (int k = 0; k < 78; k++) begin
            s_mem[i] = ref_rotl(s_mem[i] + a + b, 5'd3);
            a        = s_mem[i];
            ab       = a + b;
            l[j]     = ref_rotl(l[j] + ab, ab[4:0]);
            b        = l[j];
            i        = (i + 1) % 26;
            j        = (j + 1) % 4;
        end
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a block, wait (bounded) for accept, record the expectation.
    // Returns one cycle after the accepting edge.
    task automatic send_block(input logic [31:0] a, input logic [31:0] b, output bit ok);
        ok      = 1'b0;
        iPlainA = a;
        iPlainB = b;
        iValid  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (oReady === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) exp_q.push_back(ref_encrypt(a, b));
        step();
        iValid = 1'b0;
    endtask

    // Count edges from accept until oValid rises (bounded).
    task automatic wait_valid(output int n);
        n = 1;
        while (oValid !== 1'b1 && n < 80) begin
            step();
            n++;
        end
    endtask

    task automatic take_output(input int hold, output block_t got);
        for (int k = 0; k < hold; k++) step();
        got.a  = oCipherA;
        got.b  = oCipherB;
        iReady = 1'b1;
        step();
        iReady = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; iKeyReady = 1'b0; iValid = 1'b0; iReady = 1'b0;
        iPlainA = '0; iPlainB = '0;
        fill_s_const(32'h0);
        step(); step();
        tests_run++;
        if (oValid !== 1'b0) begin tests_failed++; $display("FAIL reset_oValid got=%b want=0", oValid); end
        tests_run++;
        if (oS_address !== 5'd0) begin tests_failed++; $display("FAIL reset_addr got=%0d want=0", oS_address); end
        tests_run++;
        if (oCipherA !== 32'h0 || oCipherB !== 32'h0) begin
            tests_failed++; $display("FAIL reset_cipher got=%h/%h want=0/0", oCipherA, oCipherB);
        end
        tests_run++;
        if (oReady !== 1'b0) begin tests_failed++; $display("FAIL reset_oReady_nokey got=%b want=0", oReady); end
        rst = 1'b1;
        iKeyReady = 1'b1;
        #1;
        tests_run++;
        if (oReady !== 1'b1) begin tests_failed++; $display("FAIL reset_oReady_key got=%b want=1", oReady); end
        step();
    endtask

    task automatic test_zero_table();
        bit ok; int n; block_t got, exp;
        fill_s_const(32'h0);
        send_block(32'h0, 32'h0, ok);
        wait_valid(n);
        tests_run++;
        if (!ok || n !== 28) begin tests_failed++; $display("FAIL zero_latency got=%0d want=28 accepted=%b", n, ok); end
        take_output(0, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp || got !== 64'h0) begin
            tests_failed++; $display("FAIL zero_cipher got=%h want=%h", got, 64'h0);
        end
    endtask

    task automatic test_key_vector();
        bit ok; int n; block_t got, exp;
        fill_s_zero_key();
        send_block(32'h0, 32'h0, ok);
        wait_valid(n);
        take_output(1, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got.a !== 32'hEEDBA521 || got.b !== 32'h6D8F4B15) begin
            tests_failed++; $display("FAIL key_vector got=%h/%h want=EEDBA521/6D8F4B15", got.a, got.b);
        end
        tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL key_vector_model got=%h want=%h", got, exp); end
    endtask

    task automatic test_keyready_gate();
        int n; logic [4:0] addr0; block_t got, exp; bit bad;
        iKeyReady = 1'b0;
        iPlainA   = 32'h01234567;
        iPlainB   = 32'h89ABCDEF;
        iValid    = 1'b1;
        addr0     = oS_address;
        bad       = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (oReady !== 1'b0 || oS_address !== addr0 || oValid !== 1'b0) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++; $display("FAIL keyready_gate got=rdy%b addr%0d val%b want=rdy0 addr%0d val0", oReady, oS_address, oValid, addr0);
        end
        iKeyReady = 1'b1;
        #1;
        tests_run++;
        if (oReady !== 1'b1) begin tests_failed++; $display("FAIL keyready_rise got=%b want=1", oReady); end
        exp_q.push_back(ref_encrypt(iPlainA, iPlainB));
        step();
        iValid = 1'b0;
        #1;
        tests_run++;
        if (oReady !== 1'b0 || oS_address !== 5'd0) begin
            tests_failed++; $display("FAIL keyready_accept got=rdy%b addr%0d want=rdy0 addr0", oReady, oS_address);
        end
        // Key-ready drop mid-block must not disturb the block.
        iKeyReady = 1'b0;
        wait_valid(n);
        iKeyReady = 1'b1;
        tests_run++;
        if (n !== 28) begin tests_failed++; $display("FAIL keyready_latency got=%0d want=28", n); end
        take_output(0, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL keyready_cipher got=%h want=%h", got, exp); end
    endtask

    task automatic test_backpressure();
        bit ok; int n; block_t held, exp; bit bad;
        fill_s_random();
        send_block($urandom, $urandom, ok);
        wait_valid(n);
        held.a = oCipherA;
        held.b = oCipherB;
        bad    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (oValid !== 1'b1 || oCipherA !== held.a || oCipherB !== held.b || oReady !== 1'b0) bad = 1'b1;
            step();
        end
        tests_run++;
        if (bad) begin
            tests_failed++; $display("FAIL bp_hold got=val%b %h/%h rdy%b want=val1 %h/%h rdy0", oValid, oCipherA, oCipherB, oReady, held.a, held.b);
        end
        iReady = 1'b1;
        #1;
        tests_run++;
        if (oReady !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_during_take got=%b want=0", oReady); end
        step();
        iReady = 1'b0;
        tests_run++;
        if (oValid !== 1'b0 || oReady !== 1'b1) begin
            tests_failed++; $display("FAIL bp_release got=val%b rdy%b want=val0 rdy1", oValid, oReady);
        end
        exp = exp_q.pop_front();
        tests_run++;
        if (held !== exp) begin tests_failed++; $display("FAIL bp_cipher got=%h want=%h", held, exp); end
    endtask

    task automatic test_reset_abort();
        bit ok; int n; block_t got, exp; bit seen;
        fill_s_random();
        send_block($urandom, $urandom, ok);
        for (int k = 1; k < 12; k++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        void'(exp_q.pop_back());
        tests_run++;
        if (oValid !== 1'b0 || oS_address !== 5'd0 || oCipherA !== 32'h0 || oCipherB !== 32'h0 || oReady !== 1'b1) begin
            tests_failed++; $display("FAIL abort_state got=val%b addr%0d %h/%h rdy%b want=val0 addr0 0/0 rdy1", oValid, oS_address, oCipherA, oCipherB, oReady);
        end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (oValid !== 1'b0) seen = 1'b1;
            step();
        end
        tests_run++;
        if (seen) begin tests_failed++; $display("FAIL abort_no_output got=oValid_seen want=none"); end
        send_block($urandom, $urandom, ok);
        wait_valid(n);
        take_output(0, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp || n !== 28) begin
            tests_failed++; $display("FAIL abort_next got=%h lat%0d want=%h lat28", got, n, exp);
        end
    endtask

    task automatic test_wrap_and_random();
        bit ok; int n; block_t got, exp;
        fill_s_const(32'h0000001F);
        send_block(32'h80000000, 32'h0, ok);
        wait_valid(n);
        take_output(0, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL wrap_cipher got=%h want=%h", got, exp); end
        for (int blk = 0; blk < 100; blk++) begin
            if (blk == 50) fill_s_random();
            if (blk > 50 && (blk % 10) == 0) fill_s_random();
            send_block($urandom, $urandom, ok);
            wait_valid(n);
            tests_run++;
            if (!ok || n !== 28) begin
                tests_failed++; $display("FAIL rand_latency blk=%0d got=%0d want=28", blk, n);
            end
            take_output(int'($urandom_range(0, 2)), got);
            if (exp_q.size() == 0) begin
                tests_run++; tests_failed++;
                $display("FAIL rand_scoreboard blk=%0d got=empty want=entry", blk);
            end else begin
                exp = exp_q.pop_front();
                tests_run++;
                if (got !== exp) begin
                    tests_failed++; $display("FAIL rand_cipher blk=%0d got=%h want=%h", blk, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_table();
        test_key_vector();
        test_keyready_gate();
        test_backpressure();
        test_reset_abort();
        test_wrap_and_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
